// File: rtl/dsp_pkg.sv
// Shared DSP helpers: saturation limits, round-half-up shift, drop counter width.
// Arithmetic is done in CALC_W bits so any filter word up to 64 bits plus its rounding add fits.
package dsp_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int CALC_W     = 65;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t max;
        calc_t min;
    } sat_lim_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ACTIVE,
        OCC_FULL
    } occ_t;

    function automatic sat_lim_t sat_limits(input int w);
        sat_lim_t lim;
        lim.max = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lim.min = -(calc_t'(1) <<< (w - 1));
        return lim;
    endfunction

    // Ties round toward +inf: the floor of the arithmetic shift after adding half an LSB.
    function automatic calc_t round_shift(input calc_t x, input int sh);
        calc_t r;
        r = x;
        if (sh > 0) begin
            r = (x + (calc_t'(1) <<< (sh - 1))) >>> sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: a push into an empty FIFO is visible at dout after one edge.
// The caller never pushes when full without a pop; the head register holds when empty.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       din,
    output logic [width-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] level
);

    localparam int PW = $clog2(depth);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [width-1:0] dout_q, dout_d;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        // The head register is refilled either straight from din (nothing else left) or from storage.
        if (push && (level_q == '0 || (pop && level_q == LW'(1)))) begin
            dout_d = din;
        end else if (pop && level_q > LW'(1)) begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/iir_output_buffer.sv
// Rounds/saturates the IIR output, buffers it in a FWFT FIFO, drains over valid/ready.
// One-cycle latency into an empty FIFO; when full, a sample without a same-cycle pop is dropped and counted.
module iir_output_buffer
    import dsp_pkg::*;
#(
    parameter int bitwidth   = 32,
    parameter int out_width  = 16,
    parameter int frac_shift = 0,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [bitwidth-1:0]    x_in,
    input  logic                          in_valid,
    output logic signed [out_width-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(fifo_depth):0]   level,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    output logic [DROP_CNT_W-1:0]         drop_count,
    input  logic                          clear_flags
);

    localparam sat_lim_t LIM = sat_limits(out_width);

    calc_t                 x_ext;
    calc_t                 r;
    logic                  clip;
    logic [out_width-1:0]  y_sat;

    always_comb begin
        x_ext = calc_t'(x_in);
        r     = round_shift(x_ext, frac_shift);
        clip  = 1'b0;
        y_sat = r[out_width-1:0];
        if (r > LIM.max) begin
            y_sat = LIM.max[out_width-1:0];
            clip  = 1'b1;
        end else if (r < LIM.min) begin
            y_sat = LIM.min[out_width-1:0];
            clip  = 1'b1;
        end
    end

    logic fifo_full, fifo_empty;
    logic push, pop, drop;
    occ_t occ;

    always_comb begin
        occ = OCC_ACTIVE;
        if (fifo_empty)     occ = OCC_EMPTY;
        else if (fifo_full) occ = OCC_FULL;
    end

    assign out_valid = (occ != OCC_EMPTY);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((occ != OCC_FULL) || pop);
    assign drop      = in_valid && (occ == OCC_FULL) && !pop;

    logic [out_width-1:0] fifo_dout;

    sync_fifo #(
        .width (out_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (y_sat),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_data = fifo_dout;

    logic                  sat_q, sat_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A clip or drop in the same cycle as clear_flags survives the clear.
    always_comb begin
        sat_d      = (sat_q & ~clear_flags) | (in_valid & clip);
        ovf_d      = (ovf_q & ~clear_flags) | drop;
        drop_cnt_d = drop_cnt_q;
        if (clear_flags) begin
            drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sat_flag   = sat_q;
    assign ovf_flag   = ovf_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_iir_output_buffer.sv
// Drives two buffers (frac_shift 0 and 4) with shared stimulus and checks both against a queue model.
module tb_iir_output_buffer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] x_in = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               clear_flags = 1'b0;

    logic signed [15:0] a_data, b_data;
    logic               a_vld, b_vld, a_sat, b_sat, a_ovf, b_ovf;
    logic [4:0]         a_lvl, b_lvl;
    logic [15:0]        a_drop, b_drop;

    iir_output_buffer #(.bitwidth(32), .out_width(16), .frac_shift(0), .fifo_depth(16)) dut_a (
        .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid),
        .out_data(a_data), .out_valid(a_vld), .out_ready(out_ready), .level(a_lvl),
        .sat_flag(a_sat), .ovf_flag(a_ovf), .drop_count(a_drop), .clear_flags(clear_flags)
    );

    iir_output_buffer #(.bitwidth(32), .out_width(16), .frac_shift(4), .fifo_depth(16)) dut_b (
        .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid),
        .out_data(b_data), .out_valid(b_vld), .out_ready(out_ready), .level(b_lvl),
        .sat_flag(b_sat), .ovf_flag(b_ovf), .drop_count(b_drop), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint qa[$];
    longint qb[$];
    bit     m_sat_a, m_sat_b, m_ovf;
    int     m_drop;

    function automatic longint cond(input longint x, input int sh);
        longint r;
        r = x;
        if (sh > 0) r = (x + (longint'(1) << (sh - 1))) >>> sh;
        return r;
    endfunction

    function automatic longint clamp(input longint r);
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_sat_a = 0;
        m_sat_b = 0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    task automatic check_all();
        chk("a_level", a_lvl, qa.size());
        chk("b_level", b_lvl, qb.size());
        chk("a_valid", a_vld, qa.size() > 0);
        chk("b_valid", b_vld, qb.size() > 0);
        if (qa.size() > 0) chk("a_data", a_data, qa[0]);
        if (qb.size() > 0) chk("b_data", b_data, qb[0]);
        chk("a_sat", a_sat, m_sat_a);
        chk("b_sat", b_sat, m_sat_b);
        chk("a_ovf", a_ovf, m_ovf);
        chk("b_ovf", b_ovf, m_ovf);
        chk("a_drop", a_drop, m_drop);
        chk("b_drop", b_drop, m_drop);
    endtask

    // One clock: apply inputs, advance the model on the edge, then compare.
    task automatic cyc(input bit iv, input int x, input bit rdy, input bit clr);
        longint ra, rb;
        bit pop, full, push, drop;
        in_valid    = iv;
        x_in        = x;
        out_ready   = rdy;
        clear_flags = clr;
        ra   = cond(x, 0);
        rb   = cond(x, 4);
        pop  = (qa.size() > 0) && rdy;
        full = (qa.size() == 16);
        push = iv && (!full || pop);
        drop = iv && full && !pop;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (push) begin
            qa.push_back(clamp(ra));
            qb.push_back(clamp(rb));
        end
        if (clr) begin
            m_sat_a = 0;
            m_sat_b = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end
        if (iv && clamp(ra) != ra) m_sat_a = 1;
        if (iv && clamp(rb) != rb) m_sat_b = 1;
        if (drop) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
        end
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_data", a_data, 0);
        chk("rst_valid", a_vld, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_all();

        // Saturation on the unshifted instance
        cyc(1, 40000, 0, 0);
        chk("sat_max", a_data, 32767);
        chk("sat_flag", a_sat, 1);
        cyc(1, -40000, 1, 0);
        chk("sat_min", a_data, -32768);
        cyc(1, 1234, 1, 0);
        chk("pass_thru", a_data, 1234);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);

        // Round-half-up on the shift-by-4 instance
        cyc(1, 24, 0, 0);
        chk("round_24", b_data, 2);
        cyc(1, 23, 1, 0);
        chk("round_23", b_data, 1);
        cyc(1, -24, 1, 0);
        chk("round_m24", b_data, -1);
        cyc(0, 0, 1, 0);

        // Fill past full, then drain in order
        for (int i = 1; i <= 20; i++) cyc(1, i, 0, 0);
        chk("fill_level", a_lvl, 16);
        chk("fill_ovf", a_ovf, 1);
        chk("fill_drop", a_drop, 4);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", a_data, i);
            cyc(0, 0, 1, 0);
        end

        // Push and pop together while full
        for (int i = 0; i < 16; i++) cyc(1, 200 + i, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 300 + k, 1, 0);
        chk("pp_level", a_lvl, 16);
        chk("pp_drop", a_drop, 4);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);

        // Asynchronous reset at level 7 with flags set
        for (int i = 0; i < 7; i++) cyc(1, 50000, 0, 0);
        chk("pre_rst_level", a_lvl, 7);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_level", a_lvl, 0);
        chk("arst_valid", a_vld, 0);
        chk("arst_data", a_data, 0);
        chk("arst_sat", a_sat, 0);
        chk("arst_ovf", a_ovf, 0);
        chk("arst_drop", a_drop, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 55, 0, 0);
        chk("post_rst_valid", a_vld, 1);
        chk("post_rst_data", a_data, 55);
        cyc(0, 0, 1, 0);

        // clear_flags coinciding with a drop
        for (int i = 0; i < 16; i++) cyc(1, i, 0, 0);
        cyc(1, 99, 0, 1);
        chk("race_ovf", a_ovf, 1);
        chk("race_drop", a_drop, 1);
        cyc(0, 0, 0, 1);
        chk("clr_ovf", a_ovf, 0);
        chk("clr_drop", a_drop, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);

        // Randomized traffic, slow consumer then fast consumer
        for (int n = 0; n < 600; n++) begin
            int x;
            if ($urandom_range(0, 9) == 0) x = int'($urandom());
            else x = int'($urandom_range(0, 200000)) - 100000;
            cyc($urandom_range(0, 3) != 0, x,
                (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_output_buffer.md
# iir_output_buffer

Downstream stage of the second-order IIR filter. It captures the filter's wide signed output `y` on a sample strobe, then rounds and saturates it to a narrower output word. Samples are buffered in a small first-word-fall-through FIFO and drained to the consumer (DAC interface or capture logic) over a valid/ready handshake. Sticky flags and a drop counter report saturation and overflow.

## Interface
- `bitwidth`, 32, width of the filter output sample `x_in`
- `out_width`, 16, width of the emitted sample; must be ≤ `bitwidth`
- `frac_shift`, 0, arithmetic right shift (round-half-up) applied before saturation; range 0..`bitwidth`-`out_width`
- `fifo_depth`, 16, FIFO entries; power of two, ≥ 2
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `x_in`  in  `bitwidth`  signed filter output sample
- `in_valid`  in  1  sample strobe; `x_in` is captured in each cycle this is high
- `out_data`  out  `out_width`  signed sample at the FIFO head
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` && `out_ready`
- `level`  out  log2(`fifo_depth`)+1  current FIFO occupancy
- `sat_flag`  out  1  sticky: at least one sample was clipped
- `ovf_flag`  out  1  sticky: at least one sample was dropped
- `drop_count`  out  16  number of dropped samples; saturates at 65535
- `clear_flags`  in  1  synchronous clear of `sat_flag`, `ovf_flag` and `drop_count`

## Operation
- Conditioning:
  - r = (`x_in` + (`frac_shift`>0 ? 2^(`frac_shift`-1) : 0)) >>> `frac_shift`.
  - Compute in `bitwidth`+1 bits so the rounding add cannot wrap.
- Saturation:
  - If r > 2^(`out_width`-1)-1, the result is MAX.
  - If r < -2^(`out_width`-1), the result is MIN.
  - Otherwise the result is the truncation of r to `out_width` bits.
  - Each clip sets `sat_flag`, including clips on samples that are later dropped.
- Push: `in_valid` and (not full, or a pop in the same cycle).
- Pop: `out_valid` && `out_ready`.
- Occupancy states, derived from `level`:
  - EMPTY (0): `out_valid`=0; a push moves to ACTIVE.
  - ACTIVE (1..depth-1): a push with no pop increments `level`; a pop with no push decrements it; push and pop together leave it unchanged.
  - FULL (depth): `in_valid` without a pop drops the sample, leaves the FIFO contents unchanged, sets `ovf_flag` and increments `drop_count`. `in_valid` with a pop is a legal push and `level` stays at depth.
- Pointers are log2(`fifo_depth`) bits and wrap modulo depth. Full/empty are distinguished by `level`, not by pointer equality.
- `clear_flags`:
  - Acts in the cycle it is sampled high.
  - If a drop or clip coincides with the clear, the new event wins: the flag stays 1, and `drop_count` becomes 1 if a drop occurred.
  - FIFO contents are unaffected.
- When `out_valid`=0, `out_data` holds its last value. The consumer must ignore it.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `out_valid`=0, `out_data`=0, `level`=0
  - `sat_flag`=0, `ovf_flag`=0, `drop_count`=0
  - both pointers 0
- Reset mid-stream discards all buffered samples. The first `in_valid` after `rst` deasserts is captured normally.
- Latency: a sample pushed into an empty FIFO at edge N has `out_valid`=1 after edge N, i.e. it is visible in the next cycle.
- `level`, the flags and `drop_count` are registered and update on the same edge as the triggering push, pop or drop.
- The consumer may hold `out_ready` high continuously; sustained throughput is one sample per clock.
- Once `out_valid` rises, `out_data` is stable until popped. The block never retracts `out_valid` without a pop.

## Structure
- Shared package `dsp_pkg` holds:
  - a function returning the saturation limits MAX and MIN for a given width
  - a `round_shift` helper
  - the `drop_count` width constant (16)
- Sub-module `sync_fifo` (parameters `width`, `depth`):
  - owns the storage array, pointers and `level`
  - exposes push/pop/full/empty
  - has the same clock and reset as the parent
- The top module contains the conditioning datapath, the drop/flag logic and the handshake.

## Test plan
- **Saturation:** `bitwidth`=32, `out_width`=16, `frac_shift`=0.
  - Push 40000 → `out_data`=32767, `sat_flag`=1.
  - Push -40000 → -32768.
  - Push 1234 → 1234, with no new clip.
- **Rounding:** `frac_shift`=4.
  - Push 24 → 2, and push 23 → 1.
  - Push -24 → -1, since round-half-up rounds toward +∞ on ties.
- **Fill and overflow:** hold `out_ready`=0, `fifo_depth`=16, push values 1..20.
  - `level`=16, `ovf_flag`=1, `drop_count`=4.
  - Draining then yields exactly 1..16 in order.
- **Simultaneous push/pop at FULL:** FIFO full, assert `in_valid` and `out_ready` together for 8 cycles.
  - `level` stays 16 and `drop_count` is unchanged.
  - Data ordering is preserved across pointer wrap.
- **Reset mid-operation:** pulse `rst` low for 1 cycle at `level`=7 with flags set.
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - The next push appears with `out_valid`=1 one cycle later.
- **clear_flags race:** assert `clear_flags` in the same cycle as a drop at FULL.
  - `ovf_flag`=1 and `drop_count`=1.
  - Asserting `clear_flags` again with no events gives `drop_count`=0 and `ovf_flag`=0.
